fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register that feeds the control decoder. It keeps the program counter and issues requests to instruction memory under a request/acknowledge handshake. It splits each returned 16-bit instruction into OpCode, Op1, Op2 and FuncCode fields and presents them as the IF/ID register. It honours stall requests from the hazard unit and flushes the pipeline on a taken branch.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, byte increment applied per accepted instruction
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  16  fetch address, stable while imem_req=1
- imem_ack  in  1  instruction valid this cycle; may arrive in the same cycle as the request or later
- imem_rdata  in  16  instruction word, sampled only when imem_ack=1
- stall  in  1  hold IF/ID and stop PC advance
- branch_taken  in  1  flush and redirect the PC
- branch_target  in  16  new PC when branch_taken=1
- ifid_valid  out  1  IF/ID holds a real instruction; 0 means bubble
- ifid_pc  out  16  address of the IF/ID instruction
- ifid_opcode  out  4  instr[15:12]
- ifid_op1  out  4  instr[11:8]
- ifid_op2  out  4  instr[7:4]
- ifid_funccode  out  4  instr[3:0]

## Operation
- States:
  - IDLE: reset state, imem_req=0.
  - FETCH: request outstanding.
  - HOLD: returned instruction buffered while stalled.
  - DRAIN: squashed request awaiting its ack.
- IDLE -> FETCH unconditionally one cycle after reset deasserts.
- imem_req is 1 in FETCH and DRAIN, 0 in IDLE and HOLD.
- imem_addr = pc in FETCH. In DRAIN it is the squashed address, held until ack.
- FETCH, ack=1, stall=0, no branch:
  - Load IF/ID with rdata and pc.
  - pc <= pc + PC_STEP, modulo 2^16 wrap.
  - Stay in FETCH.
- FETCH, ack=1, stall=1: capture rdata and pc into the hold buffer, go to HOLD. IF/ID and pc unchanged.
- HOLD, stall=0: move the buffer to IF/ID, pc += PC_STEP, go to FETCH.
- stall=1 with no ack: IF/ID contents are held. In FETCH the request stays asserted.
- branch_taken has priority over stall and ack:
  - ifid_valid <= 0, and the fields are zeroed (bubble).
  - pc <= branch_target.
  - Hold buffer discarded.
  - From FETCH with ack=1, or from HOLD: go to FETCH at the target.
  - From FETCH with ack=0: go to DRAIN. The old request stays asserted and its data is discarded on ack, then FETCH at the target.
  - branch_taken during DRAIN: pc updates to the newest target, state stays DRAIN.
- When ifid_valid=0, all ifid_* fields read 0.
- Reset mid-request: the pending ack is ignored; the memory side is required to drop the transaction on rst.

## Timing
- Reset values:
  - imem_req=0
  - imem_addr=RESET_PC
  - ifid_valid=0
  - ifid_pc=0
  - all ifid fields 0
  - pc=RESET_PC
- First request in the cycle after rst falls.
- Latency: ack in cycle N with stall=0 gives valid IF/ID in N+1. The next request address (pc+PC_STEP) is also visible in N+1.
- Throughput: 1 instruction per cycle when ack is returned in the same cycle as the request.
- branch_taken in cycle N gives ifid_valid=0 in N+1, and imem_addr=branch_target in N+1 unless the stage enters DRAIN.
- Stall release from HOLD: IF/ID updates on the edge after stall falls; the next request issues in that same cycle.

## Structure
- Shared cpu_pkg holds:
  - INSTR_W=16
  - field bit positions for opcode, op1, op2 and funccode
  - fetch-state enum (IDLE, FETCH, HOLD, DRAIN)
- One sub-module, ifid_reg: the pipeline register with load, hold and clear inputs and field split.
- The state machine, PC and hold buffer live in fetch_stage.

## Test plan
- Reset, then same-cycle ack with instructions 16'h8123, 16'h0459 -> imem_addr 0, 2, 4 on consecutive cycles; IF/ID shows opcode 8/op1 1/op2 2/func 3, then 0/4/5/9; ifid_valid=1 from cycle 2.
- Ack delayed 3 cycles on addr 0 -> imem_req and imem_addr=0 held for 3 cycles; ifid_valid stays 0 until the cycle after ack.
- stall=1 for 4 cycles while ack=1 returns 16'hB0F1 -> IF/ID holds its prior instruction and pc is unchanged. One cycle after stall falls, IF/ID=B0F1 and imem_addr advances by 2.
- branch_taken with target 16'h0040 while a request is outstanding, ack 2 cycles later -> ifid_valid=0 next cycle; the late data is never loaded; the next request goes to addr 0x40.
- branch_taken together with stall and ack in the same cycle -> bubble, buffer dropped, next imem_addr=target.
- PC at 16'hFFFE accepted -> next imem_addr=16'h0000; rst asserted mid-HOLD -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, field positions and fetch states.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int FIELD_W = 4;

    // Bit positions of the four instruction fields (least significant bit of each).
    localparam int OPCODE_LSB = 12;
    localparam int OP1_LSB    = 8;
    localparam int OP2_LSB    = 4;
    localparam int FUNC_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // reset state, no request
        FETCH = 2'd1,   // request outstanding at pc
        HOLD  = 2'd2,   // returned instruction parked while stalled
        DRAIN = 2'd3    // squashed request waiting for its ack
    } fetch_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] opcode;
        logic [FIELD_W-1:0] op1;
        logic [FIELD_W-1:0] op2;
        logic [FIELD_W-1:0] funccode;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.opcode   = instr[OPCODE_LSB +: FIELD_W];
        f.op1      = instr[OP1_LSB    +: FIELD_W];
        f.op2      = instr[OP2_LSB    +: FIELD_W];
        f.funccode = instr[FUNC_LSB   +: FIELD_W];
        return f;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads a new instruction, holds, or becomes a bubble.
// A bubble always carries all-zero fields and pc.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                hold,
    input  logic                clear,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [ADDR_W-1:0]   pc_in,
    output logic                valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [FIELD_W-1:0]  opcode,
    output logic [FIELD_W-1:0]  op1,
    output logic [FIELD_W-1:0]  op2,
    output logic [FIELD_W-1:0]  funccode
);

    logic          valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_fields_t fields_q, fields_d;

    // Next register contents: clear wins, then load, then hold; otherwise a bubble.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        valid_d  = 1'b0;
        pc_d     = '0;
        fields_d = '0;
        if (clear) begin
            valid_d  = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            pc_d     = pc_in;
            fields_d = split_instr(instr_in);
        end else if (hold) begin
            valid_d  = valid_q;
            pc_d     = pc_q;
            fields_d = fields_q;
        end
    end

    // Register update with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            fields_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            fields_q <= fields_d;
        end
    end

    assign valid    = valid_q;
    assign pc       = pc_q;
    assign opcode   = fields_q.opcode;
    assign op1      = fields_q.op1;
    assign op2      = fields_q.op2;
    assign funccode = fields_q.funccode;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request/ack handshake to instruction memory,
// stall hold buffer, branch flush, and the IF/ID register feeding the decoder.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = 16'd2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                ifid_valid,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [FIELD_W-1:0]  ifid_opcode,
    output logic [FIELD_W-1:0]  ifid_op1,
    output logic [FIELD_W-1:0]  ifid_op2,
    output logic [FIELD_W-1:0]  ifid_funccode
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;

    logic               ifid_load, ifid_hold, ifid_clear;
    logic [INSTR_W-1:0] ifid_instr_in;
    logic [ADDR_W-1:0]  ifid_pc_in;

    // Next-state, PC, hold buffer and IF/ID control. Branch beats stall beats ack.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        ifid_load     = 1'b0;
        ifid_hold     = 1'b0;
        ifid_clear    = 1'b0;
        ifid_instr_in = imem_rdata;
        ifid_pc_in    = pc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ifid_clear = 1'b1;
                end
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ifid_clear = 1'b1;
                    if (!imem_ack) begin
                        // The old request cannot be withdrawn; wait out its ack.
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ack && stall) begin
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = pc_q;
                    ifid_hold    = 1'b1;
                    state_d      = HOLD;
                end else if (imem_ack) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + PC_STEP;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ifid_clear = 1'b1;
                    state_d    = FETCH;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = hold_instr_q;
                    ifid_pc_in    = hold_pc_q;
                    pc_d          = pc_q + PC_STEP;
                    state_d       = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ifid_clear = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end
                // The squashed transaction ends on its ack even if a newer branch
                // arrives in the same cycle; otherwise keep waiting.
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (branch_taken) begin
            hold_instr_d = '0;
            hold_pc_d    = '0;
        end
    end

    // State, PC and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .hold     (ifid_hold),
        .clear    (ifid_clear),
        .instr_in (ifid_instr_in),
        .pc_in    (ifid_pc_in),
        .valid    (ifid_valid),
        .pc       (ifid_pc),
        .opcode   (ifid_opcode),
        .op1      (ifid_op1),
        .op2      (ifid_op2),
        .funccode (ifid_funccode)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage plus a streaming sequence.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [3:0]  ifid_opcode;
    logic [3:0]  ifid_op1;
    logic [3:0]  ifid_op2;
    logic [3:0]  ifid_funccode;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_opcode   (ifid_opcode),
        .ifid_op1      (ifid_op1),
        .ifid_op2      (ifid_op2),
        .ifid_funccode (ifid_funccode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected during that cycle.
    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] rdata;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        chk;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc;
        logic [15:0] instr;
    } vec_t;

    localparam int NVEC = 35;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic a, input logic [15:0] d,
                                input logic s, input logic b, input logic [15:0] t,
                                input logic c, input logic q, input logic [15:0] ad,
                                input logic v, input logic [15:0] p, input logic [15:0] ins);
        vec_t x;
        x.rst = r; x.ack = a; x.rdata = d; x.stall = s; x.br = b; x.tgt = t;
        x.chk = c; x.req = q; x.addr = ad; x.vld = v; x.ipc = p; x.instr = ins;
        return x;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every visible output against the expected IF/ID and request state.
    task automatic check_outputs(input string tag, input logic req, input logic [15:0] addr,
                                 input logic vld, input logic [15:0] ipc, input logic [15:0] instr);
        check({tag, ".imem_req"},  {15'd0, imem_req},   {15'd0, req});
        check({tag, ".imem_addr"}, imem_addr,           addr);
        check({tag, ".valid"},     {15'd0, ifid_valid}, {15'd0, vld});
        check({tag, ".pc"},        ifid_pc,             ipc);
        check({tag, ".opcode"},    {12'd0, ifid_opcode},   {12'd0, instr[15:12]});
        check({tag, ".op1"},       {12'd0, ifid_op1},      {12'd0, instr[11:8]});
        check({tag, ".op2"},       {12'd0, ifid_op2},      {12'd0, instr[7:4]});
        check({tag, ".funccode"},  {12'd0, ifid_funccode}, {12'd0, instr[3:0]});
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        //                rst ack rdata    stl br tgt       chk req addr     vld ipc      instr
        // reset, then same-cycle acks
        vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[3]  = mk(0, 1, 16'h8123, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[4]  = mk(0, 1, 16'h0459, 0, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000, 16'h8123);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0002, 16'h0459);
        // late ack on addr 4, then a normal fetch
        vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000);
        vecs[8]  = mk(0, 1, 16'h1234, 0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000);
        vecs[9]  = mk(0, 1, 16'hA5C3, 0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h0004, 16'h1234);
        // stall for 4 cycles while B0F1 returns
        vecs[10] = mk(0, 1, 16'hB0F1, 1, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0006, 16'hA5C3);
        vecs[11] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0008, 1, 16'h0006, 16'hA5C3);
        vecs[12] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0008, 1, 16'h0006, 16'hA5C3);
        vecs[13] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0008, 1, 16'h0006, 16'hA5C3);
        vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0008, 1, 16'h0006, 16'hA5C3);
        // branch while request outstanding -> DRAIN, late data discarded
        vecs[15] = mk(0, 0, 16'h0000, 0, 1, 16'h0040, 1, 1, 16'h000A, 1, 16'h0008, 16'hB0F1);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h000A, 0, 16'h0000, 16'h0000);
        vecs[17] = mk(0, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 1, 16'h000A, 0, 16'h0000, 16'h0000);
        vecs[18] = mk(0, 1, 16'h3C5A, 0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000);
        // branch together with stall and ack
        vecs[19] = mk(0, 1, 16'h7777, 1, 1, 16'h0080, 1, 1, 16'h0042, 1, 16'h0040, 16'h3C5A);
        vecs[20] = mk(0, 1, 16'h1111, 1, 0, 16'h0000, 1, 1, 16'h0080, 0, 16'h0000, 16'h0000);
        // branch out of HOLD to FFFE, then wrap
        vecs[21] = mk(0, 0, 16'h0000, 1, 1, 16'hFFFE, 1, 0, 16'h0080, 0, 16'h0000, 16'h0000);
        vecs[22] = mk(0, 1, 16'h4321, 0, 0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 16'h0000);
        vecs[23] = mk(0, 1, 16'h9876, 1, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'hFFFE, 16'h4321);
        // reset asserted mid-HOLD
        vecs[24] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hFFFE, 16'h4321);
        vecs[25] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        // ack delayed 3 cycles on addr 0
        vecs[26] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[27] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[28] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[29] = mk(0, 1, 16'hF00F, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        // stall without ack holds IF/ID; then two branches while draining
        vecs[30] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000, 16'hF00F);
        vecs[31] = mk(0, 0, 16'h0000, 0, 1, 16'h0100, 1, 1, 16'h0002, 1, 16'h0000, 16'hF00F);
        vecs[32] = mk(0, 0, 16'h0000, 0, 1, 16'h0200, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000);
        vecs[33] = mk(0, 1, 16'hBEEF, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000);
        vecs[34] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000, 16'h0000);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            imem_ack      = vecs[i].ack;
            imem_rdata    = vecs[i].rdata;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            if (vecs[i].chk) begin
                check_outputs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr,
                              vecs[i].vld, vecs[i].ipc, vecs[i].instr);
            end
        end

        // Back-to-back same-cycle acks from 0x0200: one instruction per cycle.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] word;
            @(negedge clk);
            word          = 16'h1111 * 16'(i + 1);
            imem_ack      = 1'b1;
            imem_rdata    = word;
            stall         = 1'b0;
            branch_taken  = 1'b0;
            if (i == 0) begin
                check_outputs($sformatf("s%0d", i), 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000);
            end else begin
                check_outputs($sformatf("s%0d", i), 1'b1, 16'h0200 + 16'(2 * i), 1'b1,
                              16'h0200 + 16'(2 * (i - 1)), 16'h1111 * 16'(i));
            end
        end
        @(negedge clk);
        imem_ack = 1'b0;
        check_outputs("s_last", 1'b1, 16'h020C, 1'b1, 16'h020A, 16'h6666);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
